hazard_match: RTL and testbench

- Register-address tracking pipeline that sits directly upstream of the pipeline hazard unit.
- Carries source and destination register numbers from Decode through Execute, Memory and Writeback.
- Produces the stage-to-stage address-match flags and the pending-PC-write flag that the hazard unit consumes for forwarding, load-use stall and flush decisions.
- Holds no datapath values, only register indices, valid bits and PC-write tags.

---
 rtl/hazard_match.sv | 114 +++++++++++
 tb/tb_hazard_match.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_match.sv
// Register-index tracking pipeline feeding the hazard unit.
// Produces stage-to-stage match flags and the pending PC-write flag.
module hazard_match #(
    parameter int REG_AW            = 4,
    parameter int PC_REG            = 15,
    parameter int SUPPRESS_PC_MATCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA3D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              ValidD,
    input  logic              PCSrcD,
    input  logic              CondExE,
    input  logic              FlushE,
    output logic              Match_1E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_M,
    output logic              Match_2E_W,
    output logic              Match_3E_M,
    output logic              Match_3E_W,
    output logic              Match_12D_E,
    output logic              PCWrPendingF
);

    localparam logic [REG_AW-1:0] pc_idx = REG_AW'(PC_REG);
    localparam logic              sup_pc = (SUPPRESS_PC_MATCH != 0);

    logic [REG_AW-1:0] ra1e, ra2e, ra3e, wa3e;
    logic              ve, pce;
    logic [REG_AW-1:0] wa3m;
    logic              vm, pcm;
    logic [REG_AW-1:0] wa3w;
    logic              vw;

    // Reading the PC never forwards, so a PC source index never matches.
    function automatic logic match(
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] b,
        input logic              v
    );
        logic hit;
        hit = v & (a == b);
        if (sup_pc) begin
            hit = hit & (a != pc_idx);
        end
        return hit;
    endfunction

    // Execute entry: flush inserts a bubble with zeroed indices.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ra1e <= '0;
            ra2e <= '0;
            ra3e <= '0;
            wa3e <= '0;
            ve   <= 1'b0;
            pce  <= 1'b0;
        end else begin
            ra1e <= RA1D;
            ra2e <= RA2D;
            ra3e <= RA3D;
            wa3e <= WA3D;
            ve   <= ValidD;
            pce  <= ValidD & PCSrcD;
        end
    end

    // Memory entry: a failed condition drops the PC-write tag here.
    always_ff @(posedge clk) begin
        if (reset) begin
            wa3m <= '0;
            vm   <= 1'b0;
            pcm  <= 1'b0;
        end else begin
            wa3m <= wa3e;
            vm   <= ve;
            pcm  <= pce & CondExE & ve;
        end
    end

    // Writeback entry: destination index and valid only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wa3w <= '0;
            vw   <= 1'b0;
        end else begin
            wa3w <= wa3m;
            vw   <= vm;
        end
    end

    // Match and pending flags, all forced low while reset is held.
    always_comb begin
        logic en;
        logic vem;
        logic vew;
        en           = ~reset;
        vem          = vm & ve;
        vew          = vw & ve;
        Match_1E_M   = en & match(ra1e, wa3m, vem);
        Match_1E_W   = en & match(ra1e, wa3w, vew);
        Match_2E_M   = en & match(ra2e, wa3m, vem);
        Match_2E_W   = en & match(ra2e, wa3w, vew);
        Match_3E_M   = en & match(ra3e, wa3m, vem);
        Match_3E_W   = en & match(ra3e, wa3w, vew);
        Match_12D_E  = en & ValidD
                     & (match(RA1D, wa3e, ve) | match(RA2D, wa3e, ve));
        PCWrPendingF = en & ((ValidD & PCSrcD) | pce | pcm);
    end

endmodule

// File: tb/tb_hazard_match.sv
// Vector-table bench for hazard_match, with and without PC suppression.
// Expected flags go to a scoreboard queue and are compared each cycle.
module tb_hazard_match;

    localparam logic [7:0] M1M = 8'h80;
    localparam logic [7:0] M1W = 8'h40;
    localparam logic [7:0] M2M = 8'h20;
    localparam logic [7:0] M2W = 8'h10;
    localparam logic [7:0] M3M = 8'h08;
    localparam logic [7:0] M3W = 8'h04;
    localparam logic [7:0] DE  = 8'h02;
    localparam logic [7:0] PW  = 8'h01;

    typedef struct {
        logic       rst;
        logic [3:0] ra1, ra2, ra3, wa3;
        logic       vd, pcs, cond, flush;
        logic [7:0] exp;
        logic [7:0] expns;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] exp;
        logic [7:0] expns;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1d, ra2d, ra3d, wa3d;
    logic       validd, pcsrcd, condexe, flushe;

    logic a1m, a1w, a2m, a2w, a3m, a3w, ade, apw;
    logic b1m, b1w, b2m, b2w, b3m, b3w, bde, bpw;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   row   = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    hazard_match #(.REG_AW(4), .PC_REG(15), .SUPPRESS_PC_MATCH(1)) dut (
        .clk(clk), .reset(reset),
        .RA1D(ra1d), .RA2D(ra2d), .RA3D(ra3d), .WA3D(wa3d),
        .ValidD(validd), .PCSrcD(pcsrcd),
        .CondExE(condexe), .FlushE(flushe),
        .Match_1E_M(a1m), .Match_1E_W(a1w),
        .Match_2E_M(a2m), .Match_2E_W(a2w),
        .Match_3E_M(a3m), .Match_3E_W(a3w),
        .Match_12D_E(ade), .PCWrPendingF(apw)
    );

    hazard_match #(.REG_AW(4), .PC_REG(15), .SUPPRESS_PC_MATCH(0)) dut_ns (
        .clk(clk), .reset(reset),
        .RA1D(ra1d), .RA2D(ra2d), .RA3D(ra3d), .WA3D(wa3d),
        .ValidD(validd), .PCSrcD(pcsrcd),
        .CondExE(condexe), .FlushE(flushe),
        .Match_1E_M(b1m), .Match_1E_W(b1w),
        .Match_2E_M(b2m), .Match_2E_W(b2w),
        .Match_3E_M(b3m), .Match_3E_W(b3w),
        .Match_12D_E(bde), .PCWrPendingF(bpw)
    );

    function automatic vec_t mk(
        input logic       rst,
        input logic [3:0] ra1, ra2, ra3, wa3,
        input logic       vd, pcs, cond, flush,
        input logic [7:0] exp,
        input logic [7:0] expns
    );
        vec_t v;
        v.rst = rst; v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3; v.wa3 = wa3;
        v.vd = vd; v.pcs = pcs; v.cond = cond; v.flush = flush;
        v.exp = exp; v.expns = expns;
        return v;
    endfunction

    // Drive one cycle at the falling edge, check before the rising edge.
    task automatic step(input vec_t v);
        sb_t e;
        sb_t got;
        logic [7:0] oa, ob;
        @(negedge clk);
        reset   = v.rst;
        ra1d    = v.ra1;
        ra2d    = v.ra2;
        ra3d    = v.ra3;
        wa3d    = v.wa3;
        validd  = v.vd;
        pcsrcd  = v.pcs;
        condexe = v.cond;
        flushe  = v.flush;
        e.id    = row;
        e.exp   = v.exp;
        e.expns = v.expns;
        sb.push_back(e);
        row++;
        #2;
        oa  = {a1m, a1w, a2m, a2w, a3m, a3w, ade, apw};
        ob  = {b1m, b1w, b2m, b2w, b3m, b3w, bde, bpw};
        got = sb.pop_front();
        n_cmp++;
        if (oa !== got.exp) begin
            n_bad++;
            $display("FAIL row%0d sup flags got=%b want=%b",
                     got.id, oa, got.exp);
        end
        n_cmp++;
        if (ob !== got.expns) begin
            n_bad++;
            $display("FAIL row%0d nosup flags got=%b want=%b",
                     got.id, ob, got.expns);
        end
    endtask

    initial begin
        reset = 1'b1; ra1d = '0; ra2d = '0; ra3d = '0; wa3d = '0;
        validd = 1'b0; pcsrcd = 1'b0; condexe = 1'b1; flushe = 1'b0;

        // reset, then dependency chains through E, M and W
        tbl.push_back(mk(1, 3, 0, 0, 3, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 5, 6, 4, 1, 0, 1, 0, DE, DE));
        tbl.push_back(mk(0, 7, 8, 9, 10, 1, 0, 1, 0, M1M, M1M));
        tbl.push_back(mk(0, 4, 3, 11, 12, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 12, 13, 1, 0, 1, 0, M1W, M1W));
        tbl.push_back(mk(0, 13, 0, 0, 1, 1, 0, 1, 0, M3M | DE, M3M | DE));
        tbl.push_back(mk(0, 5, 6, 13, 2, 1, 0, 1, 0, M1M, M1M));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, M3W, M3W));
        tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 1, 0, DE, DE));
        tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 1, 0,
                         M1M | M2M | M3M, M1M | M2M | M3M));
        tbl.push_back(mk(0, 7, 1, 2, 3, 1, 0, 1, 0,
                         M1W | M2W | M3W | DE, M1W | M2W | M3W | DE));
        tbl.push_back(mk(0, 9, 9, 9, 9, 1, 0, 1, 0, M1M | M1W, M1M | M1W));
        // load-use bubble: flush with D held
        tbl.push_back(mk(0, 9, 2, 0, 4, 1, 0, 1, 1, DE, DE));
        tbl.push_back(mk(0, 9, 2, 0, 4, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 5, 1, 0, 1, 0, M1W | DE, M1W | DE));
        // PC index suppression
        tbl.push_back(mk(0, 0, 1, 0, 15, 1, 0, 1, 0, M1M, M1M));
        tbl.push_back(mk(0, 1, 15, 15, 2, 1, 0, 1, 0, 0, DE));
        tbl.push_back(mk(0, 0, 15, 0, 8, 1, 0, 1, 0, 0, M2M | M3M));
        tbl.push_back(mk(0, 0, 0, 0, 6, 0, 0, 1, 0, 0, M2W));
        // PC-write tracking, condition passed
        tbl.push_back(mk(0, 0, 0, 0, 15, 1, 1, 1, 0, PW, PW));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, PW, PW));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 1, 0, PW, PW));
        tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0));
        // PC-write tracking, condition failed in Execute
        tbl.push_back(mk(0, 0, 0, 0, 15, 1, 1, 1, 0, PW, PW));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0, 0, PW, PW));
        tbl.push_back(mk(0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0));
        // invalid slots with matching indices
        tbl.push_back(mk(0, 5, 5, 5, 5, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5, 5, 5, 5, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5, 5, 5, 5, 0, 1, 1, 0, 0, 0));
        // fill the pipe with matching entries, then reset mid-flight
        tbl.push_back(mk(0, 5, 5, 5, 5, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5, 5, 5, 5, 1, 1, 1, 0, DE | PW, DE | PW));
        tbl.push_back(mk(0, 5, 5, 5, 5, 1, 0, 1, 0,
                         M1M | M2M | M3M | DE | PW,
                         M1M | M2M | M3M | DE | PW));
        tbl.push_back(mk(1, 5, 5, 5, 5, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5, 5, 5, 5, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // reset held two cycles masks a live PC write, then releases it
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, PW, PW));
        step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, DE | PW, DE | PW));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,
                M1M | M2M | M3M | PW, M1M | M2M | M3M | PW));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard left=%0d want=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
